// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one result bit per clock.
// Divide-by-zero and signed overflow complete through a one-cycle fast path.
module riscv_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    localparam int unsigned CW = $clog2(XLEN);

    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic              neg_q;   // product / quotient must be negated
    logic              neg_r;   // remainder must be negated (dividend sign)
    logic [XLEN-1:0]   mcand;   // |A| for multiply, |B| (divisor) for divide
    logic [2*XLEN-1:0] acc;     // multiply: {partial hi, multiplier}; divide: {remainder, quotient}

    logic              sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   fast_result;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quot, rem;
    logic [XLEN-1:0]   mul_res, div_res;

    // Operand decode for a new request: signs, magnitudes and fast-path detection
    always_comb begin
        sign_a      = operandA[XLEN-1] & (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
        sign_b      = operandB[XLEN-1] & (funct3 inside {3'b001, 3'b100, 3'b110});
        abs_a       = sign_a ? -operandA : operandA;
        abs_b       = sign_b ? -operandB : operandB;
        div_zero    = funct3[2] && (operandB == '0);
        div_ovf     = funct3[2] && !funct3[0] &&
                      (operandA == {1'b1, {(XLEN-1){1'b0}}}) && (operandB == '1);
        if (div_zero)
            fast_result = funct3[1] ? operandA : '1;
        else
            fast_result = funct3[1] ? '0 : operandA;
    end

    // One iteration step of each algorithm plus the sign-corrected final results
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        prod      = neg_q ? -mul_next : mul_next;
        mul_res   = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

        div_shift = acc[2*XLEN-1:XLEN-1];
        div_trial = div_shift - {1'b0, mcand};
        if (div_trial[XLEN])
            div_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        else
            div_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        quot      = div_next[XLEN-1:0];
        rem       = div_next[2*XLEN-1:XLEN];
        if (op[1])
            div_res = neg_r ? -rem : rem;
        else
            div_res = neg_q ? -quot : quot;
    end

    // Control FSM with registered busy/done/result
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op    <= funct3;
                        count <= '0;
                        busy  <= 1'b1;
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        if (div_zero || div_ovf) begin
                            result <= fast_result;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if (funct3[2]) begin
                            mcand <= abs_b;
                            acc   <= {{XLEN{1'b0}}, abs_a};
                            state <= S_DIV;
                        end else begin
                            mcand <= abs_a;
                            acc   <= {{XLEN{1'b0}}, abs_b};
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc   <= mul_next;
                    count <= count + 1'b1;
                    if (count == CW'(XLEN-1)) begin
                        result <= mul_res;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DIV: begin
                    acc   <= div_next;
                    count <= count + 1'b1;
                    if (count == CW'(XLEN-1)) begin
                        result <= div_res;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Testbench for riscv_muldiv_unit (XLEN=32): directed and random ops with a
// scoreboard queue of expected results and latencies.
module tb_riscv_muldiv_unit;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [2:0]  funct3;
    logic [31:0] operandA, operandB;
    logic        busy, done;
    logic [31:0] result;

    riscv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .operandA(operandA), .operandB(operandB), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int unsigned lat;
        string       tag;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned t0;
    logic [31:0] last_res = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea, eb, p;
        logic signed [31:0] sa, sbv;
        bit                 ovf;
        sa  = a;
        sbv = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ea  = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
        eb  = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = ea * eb;
        case (f)
            3'd0:    return p[31:0];
            3'd1,
            3'd2,
            3'd3:    return p[63:32];
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sbv);
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sbv);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int unsigned model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF) && !f[0];
        return (f[2] && (b == 0 || ovf)) ? 1 : 33;
    endfunction

    // Drive one request; T is the cycle start is high, t0 the edge that samples it
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int unsigned lat, input string tag);
        @(negedge clk);
        start = 1'b1; funct3 = f; operandA = a; operandB = b;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0; funct3 = 3'($urandom); operandA = $urandom; operandB = $urandom;
        sb.push_back('{exp, lat, tag});
    endtask

    task automatic complete();
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
        e = sb.pop_front();
        check({e.tag, " done seen"}, 32'(seen), 32'd1);
        check({e.tag, " result"}, result, e.res);
        check({e.tag, " latency"}, cyc - t0 + 1, e.lat);
        check({e.tag, " busy at done"}, 32'(busy), 32'd1);
        last_res = e.res;
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        check({tag, " done drop"}, 32'(done), 32'd0);
        check({tag, " busy drop"}, 32'(busy), 32'd0);
    endtask

    task automatic drive_at(input int unsigned e);
        for (int i = 0; i < 200 && cyc < e - 1; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        issue(f, a, b, exp, model_lat(f, a, b), tag);
        complete();
        idle_check(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        junk;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; operandA = '0; operandB = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // MUL with busy window
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
        check("mul busy T+1", 32'(busy), 32'd1);
        check("mul done T+1", 32'(done), 32'd0);
        complete();
        idle_check("mul");

        // high-half multiplies
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        run_op(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu");

        // divides
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,   32'hFFFF_FFFD, "div");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,   32'hFFFF_FFFF, "rem");
        run_op(3'b101, 32'd100,       32'd7,   32'd14,        "divu");
        run_op(3'b111, 32'd100,       32'd7,   32'd2,         "remu");

        // fast-path special cases
        run_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu by 0");
        run_op(3'b110, 32'd5,         32'd0,         32'd5,         "rem by 0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem ovf");

        // flush mid-divide, then an immediate new op
        issue(3'b100, 32'd1000, 32'd3, 32'd333, 33, "flushed div");
        drive_at(t0 + 10);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        junk = sb.pop_front();
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result held", result, last_res);
        run_op(3'b111, 32'd1000, 32'd7, 32'd6, "after flush");

        // start while busy is ignored
        issue(3'b000, 32'd12345, 32'd678, 32'd8369910, 33, "mul ignore start");
        drive_at(t0 + 5);
        start = 1'b1; funct3 = 3'b101; operandA = 32'd99; operandB = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("ignored start busy", 32'(busy), 32'd1);
        check("ignored start done", 32'(done), 32'd0);
        complete();
        idle_check("mul ignore start");

        // reset mid-operation
        issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 33, "mulh reset");
        drive_at(t0 + 20);
        reset = 1'b1;
        @(posedge clk); #1;
        junk = sb.pop_front();
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // random operations against the reference model
        for (int i = 0; i < 10; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : (i[0] ? $urandom : 32'($urandom_range(1, 300)));
            if (i == 5) ra = 32'($urandom_range(0, 1000));
            run_op(rf, ra, rb, model(rf, ra, rb), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
